// File: rtl/pcs_tx_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_pkg
// Purpose  : Shared constants and types for the PCS transmit scheduler:
//            K byte, packet type codes, header field positions, FSM state
//            and source enumerations, header builder helper.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package pcs_tx_pkg;

    localparam logic [7:0] c_K_BYTE      = 8'hBC;

    localparam logic [7:0] c_TYPE_VIDEO  = 8'h01;
    localparam logic [7:0] c_TYPE_AUDIO0 = 8'h02;
    localparam logic [7:0] c_TYPE_AUDIO1 = 8'h03;
    localparam logic [7:0] c_TYPE_UART   = 8'h04;
    localparam logic [7:0] c_TYPE_VSYNC  = 8'h05;

    // Header field LSB positions; every field above bit 23 is 8 or 16 bits.
    localparam int c_HDR_K_LSB    = 56;
    localparam int c_HDR_TYPE_LSB = 48;
    localparam int c_HDR_LEN_LSB  = 40;
    localparam int c_HDR_CNT_LSB  = 24;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_DATA = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        SRC_NONE   = 3'd0,
        SRC_VSYNC  = 3'd1,
        SRC_VIDEO  = 3'd2,
        SRC_AUDIO0 = 3'd3,
        SRC_AUDIO1 = 3'd4,
        SRC_UART   = 3'd5
    } src_t;

    function automatic logic [7:0] src_type(input src_t src);
        case (src)
            SRC_VIDEO:  src_type = c_TYPE_VIDEO;
            SRC_AUDIO0: src_type = c_TYPE_AUDIO0;
            SRC_AUDIO1: src_type = c_TYPE_AUDIO1;
            SRC_UART:   src_type = c_TYPE_UART;
            SRC_VSYNC:  src_type = c_TYPE_VSYNC;
            default:    src_type = 8'h00;
        endcase
    endfunction

    function automatic logic [63:0] build_header(input logic [7:0]  typ,
                                                 input logic [7:0]  len,
                                                 input logic [15:0] cnt);
        logic [63:0] hdr;
        hdr                        = '0;
        hdr[c_HDR_K_LSB    +: 8]  = c_K_BYTE;
        hdr[c_HDR_TYPE_LSB +: 8]  = typ;
        hdr[c_HDR_LEN_LSB  +: 8]  = len;
        hdr[c_HDR_CNT_LSB  +: 16] = cnt;
        return hdr;
    endfunction

endpackage
`default_nettype wire

// File: rtl/pcs_rr_arb3.sv
`default_nettype none
// ============================================================================
// Module   : pcs_rr_arb3
// Purpose  : 3-request round-robin arbiter. The grant is combinational from
//            the request vector and the priority pointer; the pointer only
//            moves (to the slot after the winner) when the grant is accepted.
// Ports    : clk, rst      - clock, asynchronous active-high reset
//            i_req[2:0]    - requests (bit 0 = audio0, 1 = audio1, 2 = uart)
//            i_accept      - the current grant is being used this cycle
//            o_gnt[2:0]    - one-hot grant (zero when no request)
// Revision : 1.0 - initial release
// ============================================================================
module pcs_rr_arb3 (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] i_req,
    input  logic       i_accept,
    output logic [2:0] o_gnt
);

    // r_ptr names the slot with the highest priority this cycle.
    logic [1:0] r_ptr;

    function automatic logic [2:0] pick(input logic [2:0] req, input logic [1:0] ptr);
        case (ptr)
            2'd1:    pick = req[1] ? 3'b010 : req[2] ? 3'b100 : req[0] ? 3'b001 : 3'b000;
            2'd2:    pick = req[2] ? 3'b100 : req[0] ? 3'b001 : req[1] ? 3'b010 : 3'b000;
            default: pick = req[0] ? 3'b001 : req[1] ? 3'b010 : req[2] ? 3'b100 : 3'b000;
        endcase
    endfunction

    assign o_gnt = pick(i_req, r_ptr);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 2'd0;
        end else if (i_accept) begin
            if (o_gnt[0])      r_ptr <= 2'd1;
            else if (o_gnt[1]) r_ptr <= 2'd2;
            else if (o_gnt[2]) r_ptr <= 2'd0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/pcs_tx_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : pcs_tx_scheduler
// Purpose  : PCS transmit packet scheduler. Chooses which source owns the
//            link, strobes its FIFO read enable and frames each burst as a
//            header word followed by N data words. A vsync rising edge
//            queues a zero-length frame-start marker packet.
// Ports    : i_pcs_clk / i_rst         - clock, async active-high reset
//            i_video_vsyn              - async vsync input
//            i_video_almostfull, o_video_rd_en, i_video_data      - video FIFO
//            i_audio0_almostempty, o_audio0_rd_en, i_audio0_data  - audio0 FIFO
//            i_audio1_almostempty, o_audio1_rd_en, i_audio1_data  - audio1 FIFO
//            i_uart_almostempty, o_uart_rd_en, i_uart_data        - uart FIFO
//            i_out_afull               - output FIFO near full
//            o_pcs_data/o_pcs_head/o_data_valid - output FIFO write port
// Revision : 1.0 - initial release
// ============================================================================
module pcs_tx_scheduler
    import pcs_tx_pkg::*;
#(
    parameter int P_VIDEO_BURST = 32,
    parameter int P_AUDIO_BURST = 4,
    parameter int P_UART_BURST  = 2,
    parameter int P_STARVE_MAX  = 64
) (
    input  logic        i_pcs_clk,
    input  logic        i_rst,
    input  logic        i_video_vsyn,
    input  logic        i_video_almostfull,
    output logic        o_video_rd_en,
    input  logic [63:0] i_video_data,
    input  logic        i_audio0_almostempty,
    output logic        o_audio0_rd_en,
    input  logic [63:0] i_audio0_data,
    input  logic        i_audio1_almostempty,
    output logic        o_audio1_rd_en,
    input  logic [63:0] i_audio1_data,
    input  logic        i_uart_almostempty,
    output logic        o_uart_rd_en,
    input  logic [31:0] i_uart_data,
    input  logic        i_out_afull,
    output logic [63:0] o_pcs_data,
    output logic        o_pcs_head,
    output logic        o_data_valid
);

    localparam int            c_SW          = $clog2(P_STARVE_MAX + 1);
    localparam logic [c_SW-1:0] c_STARVE_MAX = c_SW'(P_STARVE_MAX);
    localparam logic [7:0]    c_VIDEO_LEN   = 8'(P_VIDEO_BURST);
    localparam logic [7:0]    c_AUDIO_LEN   = 8'(P_AUDIO_BURST);
    localparam logic [7:0]    c_UART_LEN    = 8'(P_UART_BURST);

    state_t      r_state;
    state_t      w_state_nxt;
    src_t        r_src;
    src_t        w_sel;
    logic [7:0]  r_len;
    logic [7:0]  r_beat;
    logic [15:0] r_pkt_cnt;

    logic        r_vs_meta;
    logic        r_vs_sync;
    logic        r_vs_prev;
    logic        r_vsync_pend;
    logic        w_vs_rise;
    logic        w_marker_done;

    logic        w_video_elig;
    logic [2:0]  w_low_elig;
    logic [2:0]  w_starved;
    logic [2:0]  w_owner_low;
    logic [2:0]  w_gnt_starve;
    logic [2:0]  w_gnt_low;
    logic [2:0]  w_sel_low;
    logic        w_acc_starve;
    logic        w_acc_low;
    logic        w_rd_active;
    logic [63:0] w_burst_word;

    function automatic logic [7:0] len_of(input src_t src);
        case (src)
            SRC_VIDEO:              len_of = c_VIDEO_LEN;
            SRC_AUDIO0, SRC_AUDIO1: len_of = c_AUDIO_LEN;
            SRC_UART:               len_of = c_UART_LEN;
            default:                len_of = 8'd0;
        endcase
    endfunction

    // ------------------------------------------------------------------
    // vsync: two-flop synchronizer, rising-edge detect, sticky pending flag.
    // A new edge in the same cycle as the marker header wins over the clear
    // so that frame is not dropped.
    // ------------------------------------------------------------------
    assign w_vs_rise     = r_vs_sync & ~r_vs_prev;
    assign w_marker_done = (r_state == ST_HEAD) && (r_src == SRC_VSYNC);

    always_ff @(posedge i_pcs_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vs_meta    <= 1'b0;
            r_vs_sync    <= 1'b0;
            r_vs_prev    <= 1'b0;
            r_vsync_pend <= 1'b0;
        end else begin
            r_vs_meta <= i_video_vsyn;
            r_vs_sync <= r_vs_meta;
            r_vs_prev <= r_vs_sync;
            if (w_vs_rise)
                r_vsync_pend <= 1'b1;
            else if (w_marker_done)
                r_vsync_pend <= 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Eligibility and starvation tracking (bit 0 audio0, 1 audio1, 2 uart)
    // ------------------------------------------------------------------
    assign w_video_elig = i_video_almostfull;
    assign w_low_elig   = {~i_uart_almostempty, ~i_audio1_almostempty, ~i_audio0_almostempty};

    // A source currently owning the link is being served, so it is not
    // accumulating wait time.
    assign w_owner_low[0] = (r_state != ST_IDLE) && (r_src == SRC_AUDIO0);
    assign w_owner_low[1] = (r_state != ST_IDLE) && (r_src == SRC_AUDIO1);
    assign w_owner_low[2] = (r_state != ST_IDLE) && (r_src == SRC_UART);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_starve
            logic [c_SW-1:0] r_cnt;
            always_ff @(posedge i_pcs_clk or posedge i_rst) begin
                if (i_rst)
                    r_cnt <= '0;
                else if (!w_low_elig[gi] || w_sel_low[gi] || w_owner_low[gi])
                    r_cnt <= '0;
                else if (r_cnt != c_STARVE_MAX)
                    r_cnt <= r_cnt + c_SW'(1);
            end
            assign w_starved[gi] = w_low_elig[gi] && (r_cnt == c_STARVE_MAX);
        end
    endgenerate

    pcs_rr_arb3 u_arb_starve (
        .clk      (i_pcs_clk),
        .rst      (i_rst),
        .i_req    (w_starved),
        .i_accept (w_acc_starve),
        .o_gnt    (w_gnt_starve)
    );

    pcs_rr_arb3 u_arb_low (
        .clk      (i_pcs_clk),
        .rst      (i_rst),
        .i_req    (w_low_elig),
        .i_accept (w_acc_low),
        .o_gnt    (w_gnt_low)
    );

    // ------------------------------------------------------------------
    // Grant selection; only meaningful in IDLE with room downstream.
    // ------------------------------------------------------------------
    always_comb begin
        w_sel        = SRC_NONE;
        w_sel_low    = 3'b000;
        w_acc_starve = 1'b0;
        w_acc_low    = 1'b0;
        if ((r_state == ST_IDLE) && !i_out_afull) begin
            if (r_vsync_pend) begin
                w_sel = SRC_VSYNC;
            end else if (|w_starved) begin
                w_sel_low    = w_gnt_starve;
                w_acc_starve = 1'b1;
            end else if (w_video_elig) begin
                w_sel = SRC_VIDEO;
            end else if (|w_low_elig) begin
                w_sel_low = w_gnt_low;
                w_acc_low = 1'b1;
            end
        end
        if (w_sel_low[0])      w_sel = SRC_AUDIO0;
        else if (w_sel_low[1]) w_sel = SRC_AUDIO1;
        else if (w_sel_low[2]) w_sel = SRC_UART;
    end

    // ------------------------------------------------------------------
    // Packet FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_pcs_clk or posedge i_rst) begin
        if (i_rst)
            r_state <= ST_IDLE;
        else
            r_state <= w_state_nxt;
    end

    always_ff @(posedge i_pcs_clk or posedge i_rst) begin
        if (i_rst) begin
            r_src     <= SRC_NONE;
            r_len     <= 8'd0;
            r_beat    <= 8'd0;
            r_pkt_cnt <= 16'd0;
        end else begin
            if ((r_state == ST_IDLE) && (w_sel != SRC_NONE)) begin
                r_src  <= w_sel;
                r_len  <= len_of(w_sel);
                r_beat <= 8'd0;
            end
            if (r_state == ST_HEAD)
                r_pkt_cnt <= r_pkt_cnt + 16'd1;
            if (r_state == ST_DATA)
                r_beat <= r_beat + 8'd1;
        end
    end

    // FIFO data is valid the cycle after its read strobe, so DATA simply
    // forwards the owning FIFO's output.
    always_comb begin
        case (r_src)
            SRC_VIDEO:  w_burst_word = i_video_data;
            SRC_AUDIO0: w_burst_word = i_audio0_data;
            SRC_AUDIO1: w_burst_word = i_audio1_data;
            SRC_UART:   w_burst_word = {32'h0, i_uart_data};
            default:    w_burst_word = 64'h0;
        endcase
    end

    // Read strobes: one in HEAD plus N-1 in DATA; the last DATA cycle only
    // drains the word fetched by the previous strobe.
    always_comb begin
        w_state_nxt  = r_state;
        o_pcs_head   = 1'b0;
        o_data_valid = 1'b0;
        o_pcs_data   = 64'h0;
        w_rd_active  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_sel != SRC_NONE)
                    w_state_nxt = ST_HEAD;
            end
            ST_HEAD: begin
                o_pcs_head   = 1'b1;
                o_data_valid = 1'b1;
                o_pcs_data   = build_header(src_type(r_src), r_len, r_pkt_cnt);
                if (r_src == SRC_VSYNC) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_rd_active = 1'b1;
                    w_state_nxt = ST_DATA;
                end
            end
            ST_DATA: begin
                o_data_valid = 1'b1;
                o_pcs_data   = w_burst_word;
                if (r_beat != (r_len - 8'd1))
                    w_rd_active = 1'b1;
                else
                    w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign o_video_rd_en  = w_rd_active && (r_src == SRC_VIDEO);
    assign o_audio0_rd_en = w_rd_active && (r_src == SRC_AUDIO0);
    assign o_audio1_rd_en = w_rd_active && (r_src == SRC_AUDIO1);
    assign o_uart_rd_en   = w_rd_active && (r_src == SRC_UART);

endmodule
`default_nettype wire

// File: tb/tb_pcs_tx_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_pcs_tx_scheduler
// Purpose  : Scoreboard bench for pcs_tx_scheduler. Stimulus pushes expected
//            packets into a queue; a negedge monitor pops and compares every
//            word the DUT writes. Source FIFOs are simple counting models.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_pcs_tx_scheduler;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        vsyn = 1'b0;
    logic        vid_af = 1'b0;
    logic        a0_ae = 1'b1;
    logic        a1_ae = 1'b1;
    logic        u_ae = 1'b1;
    logic        out_afull = 1'b0;
    logic        vid_rd, a0_rd, a1_rd, u_rd;
    logic [63:0] vid_data, a0_data, a1_data;
    logic [31:0] u_data;
    logic [63:0] pcs_data;
    logic        pcs_head, data_valid;

    always #5 clk = ~clk;

    pcs_tx_scheduler dut (
        .i_pcs_clk            (clk),
        .i_rst                (rst),
        .i_video_vsyn         (vsyn),
        .i_video_almostfull   (vid_af),
        .o_video_rd_en        (vid_rd),
        .i_video_data         (vid_data),
        .i_audio0_almostempty (a0_ae),
        .o_audio0_rd_en       (a0_rd),
        .i_audio0_data        (a0_data),
        .i_audio1_almostempty (a1_ae),
        .o_audio1_rd_en       (a1_rd),
        .i_audio1_data        (a1_data),
        .i_uart_almostempty   (u_ae),
        .o_uart_rd_en         (u_rd),
        .i_uart_data          (u_data),
        .i_out_afull          (out_afull),
        .o_pcs_data           (pcs_data),
        .o_pcs_head           (pcs_head),
        .o_data_valid         (data_valid)
    );

    // Source word patterns: 0 video, 1 audio0, 2 audio1, 3 uart (zero-extended)
    function automatic logic [63:0] pat(input int src, input int unsigned s);
        case (src)
            0:       pat = {32'h7100_0000, s};
            1:       pat = {32'hA000_0000, s};
            2:       pat = {32'hA100_0000, s};
            default: pat = {32'h0, 16'hC000, s[15:0]};
        endcase
    endfunction

    // Source FIFO models: word k is presented the cycle after the k-th strobe.
    int unsigned seq_v, seq_a0, seq_a1, seq_u;
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            seq_v <= 0; seq_a0 <= 0; seq_a1 <= 0; seq_u <= 0;
            vid_data <= '0; a0_data <= '0; a1_data <= '0; u_data <= '0;
        end else begin
            if (vid_rd) begin vid_data <= pat(0, seq_v);  seq_v  <= seq_v + 1;  end
            if (a0_rd)  begin a0_data  <= pat(1, seq_a0); seq_a0 <= seq_a0 + 1; end
            if (a1_rd)  begin a1_data  <= pat(2, seq_a1); seq_a1 <= seq_a1 + 1; end
            if (u_rd)   begin u_data   <= {16'hC000, seq_u[15:0]}; seq_u <= seq_u + 1; end
        end
    end

    typedef struct packed {
        logic        head;
        logic [63:0] data;
        logic        chk_gap;
    } exp_t;

    exp_t        exp_q[$];
    int unsigned exp_seq [5];
    logic [15:0] exp_cnt = 16'd0;

    int n_cmp  = 0;
    int n_fail = 0;
    int cyc = 0;
    int last_valid = -100;
    int last_hdr_cyc = 0;
    int hdr_seen = 0;
    int rd_total = 0;
    int vid_rd_cnt = 0;

    // src: 0 video, 1 audio0, 2 audio1, 3 uart, 4 vsync marker
    task automatic push_pkt(input int src, input bit gap);
        logic [7:0] t, n;
        exp_t e;
        case (src)
            0:       begin t = 8'h01; n = 8'd32; end
            1:       begin t = 8'h02; n = 8'd4;  end
            2:       begin t = 8'h03; n = 8'd4;  end
            3:       begin t = 8'h04; n = 8'd2;  end
            default: begin t = 8'h05; n = 8'd0;  end
        endcase
        e.head    = 1'b1;
        e.data    = {8'hBC, t, n, exp_cnt, 24'h0};
        e.chk_gap = gap;
        exp_q.push_back(e);
        exp_cnt = exp_cnt + 16'd1;
        for (int k = 0; k < int'(n); k++) begin
            e.head    = 1'b0;
            e.data    = pat(src, exp_seq[src]);
            e.chk_gap = 1'b0;
            exp_q.push_back(e);
            exp_seq[src] = exp_seq[src] + 1;
        end
    endtask

    // Monitor / scoreboard
    always @(negedge clk) begin
        exp_t e;
        logic [3:0] rdv;
        if (!rst) begin
            cyc = cyc + 1;
            rdv = {u_rd, a1_rd, a0_rd, vid_rd};
            rd_total   = rd_total + $countones(rdv);
            vid_rd_cnt = vid_rd_cnt + int'(vid_rd);
            if (|rdv) begin
                n_cmp = n_cmp + 1;
                if ($countones(rdv) != 1 || !data_valid) begin
                    n_fail = n_fail + 1;
                    $display("FAIL rd_en_onehot cyc %0d: rd_en=%b valid=%b, required one-hot with valid=1",
                             cyc, rdv, data_valid);
                end
            end
            if (data_valid) begin
                n_cmp = n_cmp + 1;
                if (exp_q.size() == 0) begin
                    n_fail = n_fail + 1;
                    $display("FAIL unexpected_word cyc %0d: got head=%b data=%h, required no write",
                             cyc, pcs_head, pcs_data);
                end else begin
                    e = exp_q.pop_front();
                    if (pcs_head !== e.head || pcs_data !== e.data) begin
                        n_fail = n_fail + 1;
                        $display("FAIL word cyc %0d: got head=%b data=%h, required head=%b data=%h",
                                 cyc, pcs_head, pcs_data, e.head, e.data);
                    end
                    if (e.chk_gap) begin
                        n_cmp = n_cmp + 1;
                        if (cyc - last_valid != 2) begin
                            n_fail = n_fail + 1;
                            $display("FAIL idle_gap cyc %0d: got %0d idle cycles, required 1",
                                     cyc, cyc - last_valid - 1);
                        end
                    end
                end
                if (pcs_head) begin
                    hdr_seen     = hdr_seen + 1;
                    last_hdr_cyc = cyc;
                end
                last_valid = cyc;
            end
        end
    end

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        n_cmp = n_cmp + 1;
        if (got != req) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    task automatic check_outs_zero(input string name);
        logic [67:0] v;
        v = {vid_rd, a0_rd, a1_rd, u_rd, data_valid, pcs_head, pcs_data[61:0]} ;
        n_cmp = n_cmp + 1;
        if (v !== '0 || pcs_data !== 64'h0) begin
            n_fail = n_fail + 1;
            $display("FAIL %s: got rd=%b%b%b%b valid=%b head=%b data=%h, required all 0",
                     name, vid_rd, a0_rd, a1_rd, u_rd, data_valid, pcs_head, pcs_data);
        end
    endtask

    task automatic wait_hdr(input string name, input int target, input int budget);
        int k;
        k = 0;
        while (hdr_seen < target && k < budget) begin
            tick(1);
            k++;
        end
        if (hdr_seen < target) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d headers, required %0d within %0d cycles",
                     name, hdr_seen, target, budget);
        end
    endtask

    task automatic drain(input string name, input int budget);
        int k;
        k = 0;
        while (exp_q.size() != 0 && k < budget) begin
            tick(1);
            k++;
        end
        if (exp_q.size() != 0) begin
            n_cmp  = n_cmp + 1;
            n_fail = n_fail + 1;
            $display("FAIL %s: got %0d expected words never written, required 0",
                     name, exp_q.size());
            exp_q.delete();
        end
        tick(4);
    endtask

    task automatic vsync_pulse();
        vsyn = 1'b1;
        tick(3);
        vsyn = 1'b0;
        tick(3);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, start, wait_cyc;
        for (int i = 0; i < 5; i++) exp_seq[i] = 0;

        // Reset state
        #1;
        check_outs_zero("reset_outputs");
        tick(3);
        rst = 1'b0;
        tick(3);

        // 1: vsync marker while all sources idle
        base = rd_total;
        push_pkt(4, 1'b0);
        vsync_pulse();
        drain("t1_vsync", 40);
        check_int("t1_no_rd_en", rd_total - base, 0);

        // 2: two back-to-back video bursts, one idle cycle between them
        base = hdr_seen;
        start = vid_rd_cnt;
        push_pkt(0, 1'b0);
        push_pkt(0, 1'b1);
        vid_af = 1'b1;
        wait_hdr("t2_video_hdr", base + 2, 200);
        vid_af = 1'b0;
        drain("t2_video", 100);
        check_int("t2_video_rd_en_cycles", vid_rd_cnt - start, 64);

        // 3: round robin across audio0, audio1, uart
        base = hdr_seen;
        push_pkt(1, 1'b0);
        push_pkt(2, 1'b0);
        push_pkt(3, 1'b0);
        push_pkt(1, 1'b0);
        a0_ae = 1'b0; a1_ae = 1'b0; u_ae = 1'b0;
        wait_hdr("t3_rr_hdr", base + 4, 200);
        a0_ae = 1'b1; a1_ae = 1'b1; u_ae = 1'b1;
        drain("t3_rr", 60);

        // 4: starved audio1 preempts continuous video
        base = hdr_seen;
        push_pkt(0, 1'b0);
        push_pkt(0, 1'b0);
        push_pkt(2, 1'b0);
        start = cyc;
        vid_af = 1'b1; a1_ae = 1'b0;
        wait_hdr("t4_starve_hdr", base + 3, 300);
        vid_af = 1'b0; a1_ae = 1'b1;
        wait_cyc = last_hdr_cyc - start;
        check_int("t4_wait_ge_64", int'(wait_cyc >= 64), 1);
        check_int("t4_wait_le_97", int'(wait_cyc <= 97), 1);
        drain("t4_starve", 100);

        // 5: afull mid-burst, burst completes, nothing new starts
        base = hdr_seen;
        push_pkt(0, 1'b0);
        vid_af = 1'b1;
        wait_hdr("t5_video_hdr", base + 1, 100);
        tick(10);
        out_afull = 1'b1;
        tick(60);
        check_int("t5_no_hdr_while_afull", hdr_seen - base, 1);
        vid_af = 1'b0;
        out_afull = 1'b0;
        drain("t5_afull", 60);

        // 6: reset during DATA with a vsync pending
        base = hdr_seen;
        push_pkt(0, 1'b0);
        vid_af = 1'b1;
        wait_hdr("t6_video_hdr", base + 1, 100);
        tick(2);
        vsync_pulse();
        #2;
        rst = 1'b1;
        #1;
        check_outs_zero("t6_async_reset_outputs");
        exp_q.delete();
        exp_cnt = 16'd0;
        for (int i = 0; i < 5; i++) exp_seq[i] = 0;
        tick(3);
        rst = 1'b0;
        base = hdr_seen;
        push_pkt(0, 1'b0);
        wait_hdr("t6_after_reset_hdr", base + 1, 50);
        vid_af = 1'b0;
        drain("t6_after_reset", 60);

        // 7: packet counter wrap FFFE -> FFFF -> 0000
        force dut.r_pkt_cnt = 16'hFFFE;
        #1;
        release dut.r_pkt_cnt;
        exp_cnt = 16'hFFFE;
        for (int i = 0; i < 3; i++) begin
            push_pkt(4, 1'b0);
            vsync_pulse();
            drain("t7_wrap", 40);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
